// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared encodings for the lab clock mode scheduler
package clock_pkg;

   localparam logic [1:0] MODE_TIME  = 2'b00;
   localparam logic [1:0] MODE_ALARM = 2'b01;
   localparam logic [1:0] MODE_SW    = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RINGING = 2'b01,
      SNOOZE  = 2'b10,
      WAIT    = 2'b11
   } alarm_state_t;

   // Bit positions inside the 4-bit routed event bus
   localparam int EV_B0L = 3;
   localparam int EV_B0S = 2;
   localparam int EV_B1L = 1;
   localparam int EV_B1S = 0;

   function automatic logic [1:0] next_mode(input logic [1:0] m);
      case (m)
         MODE_TIME:  return MODE_ALARM;
         MODE_ALARM: return MODE_SW;
         default:    return MODE_TIME;
      endcase
   endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - saturating tick counter that flags the tick reaching LIMIT-1
module tick_timer #(
   parameter int LIMIT = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic done
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt;

   assign done = tick & (cnt == LAST);

   // Holds at LAST rather than wrapping; the owner clears on state exit
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (tick && (cnt != LAST)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/clock_mode_sched.sv
// rtl/clock_mode_sched.sv - display mode FSM, button event router and alarm ring/snooze FSM
module clock_mode_sched #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       bm_short,
   input  logic       b0long,
   input  logic       b0short,
   input  logic       b1long,
   input  logic       b1short,
   input  logic       setting_busy,
   input  logic       alarm_en,
   input  logic       alarm_match,
   output logic [1:0] mode,
   output logic [3:0] ev_time,
   output logic [3:0] ev_alarm,
   output logic [3:0] ev_sw,
   output logic       ring,
   output logic       ring_blink
);

   import clock_pkg::*;

   alarm_state_t state, state_n;
   logic         match_q;
   logic         blink;
   logic         match_rise;
   logic         ring_done, snooze_done;
   logic [1:0]   mode_n;
   logic [3:0]   ev_in;
   logic [3:0]   ev_time_n, ev_alarm_n, ev_sw_n;

   tick_timer #(.LIMIT(RING_SECS)) u_ring_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (state != RINGING),
      .tick  (tick_1hz & (state == RINGING)),
      .done  (ring_done)
   );

   tick_timer #(.LIMIT(SNOOZE_SECS)) u_snooze_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (state != SNOOZE),
      .tick  (tick_1hz & (state == SNOOZE)),
      .done  (snooze_done)
   );

   always_comb begin
      ev_in         = '0;
      ev_in[EV_B0L] = b0long;
      ev_in[EV_B0S] = b0short;
      ev_in[EV_B1L] = b1long;
      ev_in[EV_B1S] = b1short;
      match_rise    = alarm_match & ~match_q;

      state_n = state;
      if (!alarm_en) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:    if (match_rise) state_n = RINGING;
            RINGING: begin
               if (b0short || b1short)     state_n = WAIT;
               else if (b0long || b1long)  state_n = SNOOZE;
               else if (ring_done)         state_n = WAIT;
            end
            SNOOZE:  if (snooze_done) state_n = RINGING;
            WAIT:    if (!alarm_match) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end

      // A ring starting this cycle swallows a concurrent mode press
      mode_n = mode;
      if (mode == 2'b11) begin
         mode_n = MODE_TIME;
      end else if (bm_short && !setting_busy && (state == IDLE || state == WAIT)
                   && state_n != RINGING) begin
         mode_n = next_mode(mode);
      end

      ev_time_n  = '0;
      ev_alarm_n = '0;
      ev_sw_n    = '0;
      if (state != RINGING) begin
         case (mode)
            MODE_TIME:  ev_time_n  = ev_in;
            MODE_ALARM: ev_alarm_n = ev_in;
            MODE_SW:    ev_sw_n    = ev_in;
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         match_q    <= 1'b1;
         blink      <= 1'b0;
         mode       <= MODE_TIME;
         ev_time    <= '0;
         ev_alarm   <= '0;
         ev_sw      <= '0;
         ring       <= 1'b0;
         ring_blink <= 1'b0;
      end else begin
         state      <= state_n;
         match_q    <= alarm_match;
         blink      <= blink ^ tick_1hz;
         mode       <= mode_n;
         ev_time    <= ev_time_n;
         ev_alarm   <= ev_alarm_n;
         ev_sw      <= ev_sw_n;
         ring       <= (state_n == RINGING);
         ring_blink <= (state_n == RINGING) & (blink ^ tick_1hz);
      end
   end

endmodule
